// File: rtl/detector_cor_rgb.sv
// detector_cor_rgb -- stable RGB colour detector with handshake delivery.
// A colour pattern must stay identical for ESTAVEL consecutive samples
// before its one-hot code is delivered; the consumer acknowledges it with
// i_reconhece.
// Optional feature macro: DETECTOR_COR_ERRO_EN enables the o_erro pulse
// for a stable unmapped pattern. Without it o_erro is tied low.
module detector_cor_rgb #(
    parameter int ESTAVEL = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_habilita,
    input  logic [2:0] i_leds_rgb,
    input  logic       i_reconhece,
    output logic [3:0] o_codigo,
    output logic       o_valido,
    output logic       o_erro
);

    // Minimum width that holds ESTAVEL-1; ESTAVEL >= 2 keeps this >= 1.
    localparam int CW = $clog2(ESTAVEL);
    localparam logic [CW-1:0] LIMITE = CW'(ESTAVEL - 1);

`ifdef DETECTOR_COR_ERRO_EN
    localparam logic ERRO_EN = 1'b1;
`else
    localparam logic ERRO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        FILTRA  = 2'd1,
        ENTREGA = 2'd2,
        LIBERA  = 2'd3
    } estado_t;

    estado_t         r_estado;
    estado_t         w_estado;
    logic [2:0]      r_amostra;
    logic [2:0]      w_amostra;
    logic [CW-1:0]   r_contador;
    logic [CW-1:0]   w_contador;
    logic [3:0]      r_codigo;
    logic [3:0]      w_codigo;
    logic            r_valido;
    logic            w_valido;
    logic            r_erro;
    logic            w_erro;
    logic [3:0]      w_mapa;

    // Colour pattern to one-hot code; 0000 marks an unmapped pattern.
    function automatic logic [3:0] f_mapeia(input logic [2:0] padrao);
        logic [3:0] codigo;
        case (padrao)
            3'b100:  codigo = 4'b1000;   // verde
            3'b101:  codigo = 4'b0100;   // amarelo
            3'b010:  codigo = 4'b0010;   // azul
            3'b001:  codigo = 4'b0001;   // vermelho
            default: codigo = 4'b0000;
        endcase
        return codigo;
    endfunction

    assign w_mapa = f_mapeia(r_amostra);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_estado   = r_estado;
        w_amostra  = r_amostra;
        w_contador = r_contador;
        w_codigo   = r_codigo;
        w_valido   = r_valido;
        w_erro     = 1'b0;
        case (r_estado)
            INICIAL: begin
                w_codigo = 4'b0000;
                w_valido = 1'b0;
                if (i_habilita && (i_leds_rgb != 3'b000)) begin
                    w_amostra  = i_leds_rgb;
                    w_contador = CW'(1);
                    w_estado   = FILTRA;
                end else begin
                    w_estado   = INICIAL;
                end
            end
            FILTRA: begin
                if (!i_habilita) begin
                    w_contador = '0;
                    w_estado   = INICIAL;
                end else if (i_leds_rgb == 3'b000) begin
                    w_contador = '0;
                    w_estado   = INICIAL;
                end else if (i_leds_rgb != r_amostra) begin
                    // A different colour restarts the stability window.
                    w_amostra  = i_leds_rgb;
                    w_contador = CW'(1);
                end else if (r_contador < LIMITE) begin
                    w_contador = r_contador + CW'(1);
                end else begin
                    // ESTAVEL-th identical sample: deliver or flag.
                    w_contador = '0;
                    if (w_mapa != 4'b0000) begin
                        w_codigo = w_mapa;
                        w_valido = 1'b1;
                        w_estado = ENTREGA;
                    end else begin
                        w_erro   = ERRO_EN;
                        w_estado = LIBERA;
                    end
                end
            end
            ENTREGA: begin
                if (i_reconhece) begin
                    w_codigo = 4'b0000;
                    w_valido = 1'b0;
                    w_estado = LIBERA;
                end else begin
                    w_estado = ENTREGA;
                end
            end
            LIBERA: begin
                // A held colour must go dark before it can be seen again.
                if (i_leds_rgb == 3'b000) begin
                    w_estado = INICIAL;
                end else begin
                    w_estado = LIBERA;
                end
            end
            default: begin
                w_estado   = INICIAL;
                w_contador = '0;
                w_codigo   = 4'b0000;
                w_valido   = 1'b0;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset overriding all.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado   <= INICIAL;
            r_amostra  <= 3'b000;
            r_contador <= '0;
            r_codigo   <= 4'b0000;
            r_valido   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado   <= w_estado;
            r_amostra  <= w_amostra;
            r_contador <= w_contador;
            r_codigo   <= w_codigo;
            r_valido   <= w_valido;
            r_erro     <= w_erro;
        end
    end

    assign o_codigo = r_codigo;
    assign o_valido = r_valido;
    assign o_erro   = r_erro;

endmodule

// File: tb/tb_detector_cor_rgb.sv
// tb_detector_cor_rgb -- directed bench for detector_cor_rgb (ESTAVEL=4).
// Expected o_erro depends on DETECTOR_COR_ERRO_EN.
module tb_detector_cor_rgb;

    logic       r_clock;
    logic       r_reset;
    logic       r_habilita;
    logic [2:0] r_leds_rgb;
    logic       r_reconhece;
    logic [3:0] w_codigo;
    logic       w_valido;
    logic       w_erro;

    int n_checks;
    int n_errors;

`ifdef DETECTOR_COR_ERRO_EN
    localparam logic ERRO_ESPERADO = 1'b1;
`else
    localparam logic ERRO_ESPERADO = 1'b0;
`endif

    detector_cor_rgb #(.ESTAVEL(4)) dut (
        .i_clock     (r_clock),
        .i_reset     (r_reset),
        .i_habilita  (r_habilita),
        .i_leds_rgb  (r_leds_rgb),
        .i_reconhece (r_reconhece),
        .o_codigo    (w_codigo),
        .o_valido    (w_valido),
        .o_erro      (w_erro)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        r_clock = 1'b0;
        forever #5 r_clock = ~r_clock;
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge r_clock);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] cod, input logic val);
        check_eq({tag, "_codigo"}, {4'h0, w_codigo}, {4'h0, cod});
        check_eq({tag, "_valido"}, {7'h0, w_valido}, {7'h0, val});
    endtask

    // Acknowledge a delivered code and let the colour go dark.
    task automatic ack_and_clear(input string tag);
        r_reconhece = 1'b1;
        step(1);
        r_reconhece = 1'b0;
        check_out({tag, "_ack"}, 4'b0000, 1'b0);
        r_leds_rgb = 3'b000;
        step(1);
    endtask

    int episodes;
    int high_cycles;
    logic prev_valido;
    logic bad_code;
    int erro_cycles;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        r_reset     = 1'b1;
        r_habilita  = 1'b0;
        r_leds_rgb  = 3'b000;
        r_reconhece = 1'b0;
        step(2);
        check_out("reset", 4'b0000, 1'b0);
        check_eq("reset_erro", {7'h0, w_erro}, 8'h00);
        r_reset = 1'b0;

        // Blue held four edges, then acknowledged.
        r_habilita = 1'b1;
        r_leds_rgb = 3'b010;
        step(3);
        check_out("azul_e3", 4'b0000, 1'b0);
        step(1);
        check_out("azul_e4", 4'b0010, 1'b1);
        step(2);
        check_out("azul_hold", 4'b0010, 1'b1);
        r_reconhece = 1'b1;
        step(1);
        r_reconhece = 1'b0;
        check_out("azul_ack", 4'b0000, 1'b0);
        step(5);
        check_out("azul_held_no_redetect", 4'b0000, 1'b0);
        r_leds_rgb = 3'b000;
        step(1);

        // Green for 3 edges, then red for 4 edges.
        r_leds_rgb = 3'b100;
        step(3);
        check_out("verde_3", 4'b0000, 1'b0);
        r_leds_rgb = 3'b001;
        step(3);
        check_out("verm_e3", 4'b0000, 1'b0);
        step(1);
        check_out("verm_e4", 4'b0001, 1'b1);
        ack_and_clear("verm");

        // Yellow held 20 edges, acknowledge sampled on edge 6.
        episodes    = 0;
        high_cycles = 0;
        prev_valido = 1'b0;
        bad_code    = 1'b0;
        r_leds_rgb  = 3'b101;
        for (int e = 1; e <= 20; e++) begin
            r_reconhece = (e == 6) ? 1'b1 : 1'b0;
            step(1);
            if (w_valido) begin
                high_cycles++;
                if (w_codigo != 4'b0100) bad_code = 1'b1;
                if (!prev_valido) episodes++;
            end
            prev_valido = w_valido;
        end
        r_reconhece = 1'b0;
        check_eq("amarelo_episodes", 8'(episodes), 8'd1);
        check_eq("amarelo_high_cycles", 8'(high_cycles), 8'd2);
        check_eq("amarelo_code", {7'h0, bad_code}, 8'h00);
        r_leds_rgb = 3'b000;
        step(1);
        r_leds_rgb = 3'b101;
        step(4);
        check_out("amarelo_again", 4'b0100, 1'b1);
        ack_and_clear("amarelo2");

        // Unmapped 111 held: one-cycle erro (when enabled), never valido.
        erro_cycles = 0;
        r_leds_rgb  = 3'b111;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            if (w_erro) erro_cycles++;
            if (e == 4) check_eq("branco_erro_e4", {7'h0, w_erro}, {7'h0, ERRO_ESPERADO});
            check_eq("branco_valido", {7'h0, w_valido}, 8'h00);
        end
        check_eq("branco_erro_cycles", 8'(erro_cycles), {7'h0, ERRO_ESPERADO});
        r_leds_rgb = 3'b000;
        step(1);

        // Reset while valido is high discards the code.
        r_leds_rgb = 3'b010;
        step(4);
        check_out("pre_reset", 4'b0010, 1'b1);
        r_reset = 1'b1;
        step(1);
        check_out("mid_entrega_reset", 4'b0000, 1'b0);
        r_reset = 1'b0;
        step(3);
        check_out("post_reset_e3", 4'b0000, 1'b0);
        step(1);
        check_out("post_reset_e4", 4'b0010, 1'b1);
        ack_and_clear("post_reset");

        // habilita drops at count 2: detection restarts from scratch.
        r_leds_rgb = 3'b100;
        step(2);
        r_habilita = 1'b0;
        step(1);
        check_out("hab_off", 4'b0000, 1'b0);
        r_habilita = 1'b1;
        step(3);
        check_out("hab_restart_e3", 4'b0000, 1'b0);
        step(1);
        check_out("hab_restart_e4", 4'b1000, 1'b1);
        ack_and_clear("hab");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/detector_cor_rgb.md
DETECTOR_COR_RGB -- requirements
Module: detector_cor_rgb

Interface
REQ-001 Parameter ESTAVEL, default 4, number of consecutive identical samples required to accept a colour; legal range 2..255.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 habilita  input  1  detection enable; low aborts any unconfirmed detection.
REQ-005 leds_rgb  input  3  sampled RGB pattern; 000 means no colour.
REQ-006 reconhece  input  1  consumer acknowledge of a delivered code.
REQ-007 codigo  output  4  one-hot code: bit 3 verde, bit 2 amarelo, bit 1 azul, bit 0 vermelho; 0000 when none.
REQ-008 valido  output  1  high while codigo holds an unacknowledged detection.
REQ-009 erro  output  1  one-cycle pulse on a stable unmapped pattern.

Function
REQ-010 Mapping SHALL be: 100 -> 1000, 001 -> 0001, 010 -> 0010, 101 -> 0100; every other nonzero pattern is unmapped.
REQ-011 FSM SHALL have exactly four states: INICIAL, FILTRA, ENTREGA, LIBERA; all outputs registered.
REQ-012 INICIAL: codigo=0000, valido=0; if habilita=1 and leds_rgb!=000, capture pattern into amostra, set contador=1, go FILTRA; else stay.
REQ-013 FILTRA, habilita=0: clear contador, go INICIAL, no output change.
REQ-014 FILTRA, leds_rgb==000: go INICIAL.
REQ-015 FILTRA, leds_rgb nonzero and != amostra: reload amostra, contador=1, stay in FILTRA.
REQ-016 FILTRA, leds_rgb==amostra and contador<ESTAVEL-1: increment contador.
REQ-017 FILTRA, leds_rgb==amostra and contador==ESTAVEL-1, mapped pattern: load codigo, set valido=1, go ENTREGA; valido is therefore high after the ESTAVEL-th consecutive sampling edge.
REQ-018 Same condition with an unmapped pattern: pulse erro for one cycle (per Configuration), go LIBERA, valido stays 0.
REQ-019 ENTREGA: hold codigo and valido until reconhece=1 is sampled, then clear valido and codigo and go LIBERA; habilita and leds_rgb are ignored in this state.
REQ-020 reconhece outside ENTREGA SHALL have no effect.
REQ-021 LIBERA: stay until leds_rgb==000 is sampled, then go INICIAL; a held colour SHALL never produce a second detection.
REQ-022 contador width SHALL be the minimum that holds ESTAVEL-1; it never wraps.

Reset
REQ-023 reset=1 on a rising edge SHALL force state INICIAL, codigo=0000, valido=0, erro=0, contador=0, amostra=000, overriding all other inputs, including mid-FILTRA or mid-ENTREGA (pending code discarded).
REQ-024 First detection after reset release SHALL obey REQ-012 from the next edge.

Configuration
REQ-025 Macro DETECTOR_COR_ERRO_EN SHALL gate the erro feature.
REQ-026 With DETECTOR_COR_ERRO_EN defined: erro pulses as in REQ-018.
REQ-027 Without it: port erro exists but is tied 0; unmapped stable patterns still go silently to LIBERA.

Verification
REQ-028 ESTAVEL=4, habilita=1, leds_rgb=010 held 4 edges -> valido=1, codigo=0010 after 4th edge; reconhece pulse -> valido=0, codigo=0000 next edge.
REQ-029 leds_rgb=100 for 3 edges then 001 for 4 edges -> no detection on 100; codigo=0001 after 4th edge of 001.
REQ-030 leds_rgb=101 held 20 edges, acknowledge at edge 6 -> exactly one valido episode with codigo=0100; new detection only after leds_rgb=000 sampled.
REQ-031 leds_rgb=111 held 4 edges with macro defined -> erro=1 for exactly one cycle, valido=0; macro undefined -> erro stays 0.
REQ-032 reset=1 asserted while valido=1 -> next edge codigo=0000, valido=0; habilita=0 during FILTRA at count 2 -> return to INICIAL, no valido.
